rv32i_mem_arbiter: RTL and testbench

- Shares one single-port 32-bit memory bus between two requesters: instruction fetch and the ALU load/store path.
- Sequences each access as a req/ack bus transaction and returns read data to the requester.
- Drives the pipeline stall while a data access is outstanding.
- Sits between the fetch unit, the ALU memory port and the memory/bus interface.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/rv32i_bus_timer.sv | 42 ++++
 rtl/rv32i_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I memory arbiter slice.
//   arb_state_e       : arbiter FSM state encodings
//   grant_e           : which requester owned the most recent bus grant
//   ERR_RDATA_DEFAULT : read data returned when a bus access is aborted
package rv32i_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_FETCH_BUSY = 2'd1,
        ARB_DATA_BUSY  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/rv32i_bus_timer.sv
// Bus watchdog for the memory arbiter.
//   clk, reset : clock and synchronous active-high reset
//   run        : a bus access is in flight and m_ack is low this cycle
//   clr        : arbiter is idle; restart the count
//   expired    : combinational; high in the TIMEOUT_CYCLES-th run cycle so the
//                arbiter aborts at the end of that cycle
// TIMEOUT_CYCLES = 0 disables the watchdog.
module rv32i_bus_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            // The count only needs to reach TIMEOUT_CYCLES-1: expiry is flagged
            // combinationally during the last permitted cycle.
            localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_reg;

            // m_ack is folded into run, so a coincident ack never reports expiry.
            assign expired = run & (count_reg == LAST);

            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    count_reg <= '0;
                end else if (run && !expired) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Two-requester arbiter for a single-port 32-bit memory bus.
//   if_*   : instruction fetch port (req held until if_ack)
//   d_*    : ALU load/store port (load/store held until d_ack)
//   stall  : pipeline stall while a data access is outstanding
//   m_*    : memory bus (req/ack handshake, ack may come in the first req cycle)
//   bus_err: one-cycle pulse when an access is aborted by the watchdog
// Each access is: IDLE (grant) -> BUSY (m_req until m_ack/timeout) -> IDLE.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_load,
    input  logic        d_store,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_err
);

    arb_state_e  state_reg, state_next;
    grant_e      last_grant_reg, last_grant_next;
    logic        m_req_reg, m_req_next;
    logic        m_we_reg, m_we_next;
    logic [31:0] m_addr_reg, m_addr_next;
    logic [3:0]  m_be_reg, m_be_next;
    logic [31:0] m_wdata_reg, m_wdata_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic [31:0] d_rdata_reg, d_rdata_next;
    logic        if_ack_reg, if_ack_next;
    logic        d_ack_reg, d_ack_next;
    logic        bus_err_reg, bus_err_next;

    logic fetch_pend, data_pend, grant_data;
    logic timer_run, timer_clr, timer_expired;

    assign timer_run = (state_reg != ARB_IDLE) & ~m_ack;
    assign timer_clr = (state_reg == ARB_IDLE);

    rv32i_bus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (timer_run),
        .clr    (timer_clr),
        .expired(timer_expired)
    );

    // During an ack cycle the requester still shows its old request; no grant
    // is made then, which keeps at least one idle cycle between accesses.
    assign fetch_pend = if_req & ~(if_ack_reg | d_ack_reg);
    assign data_pend  = (d_load | d_store) & ~(if_ack_reg | d_ack_reg);
    // Round-robin on a tie: data wins unless it had the previous grant.
    assign grant_data = data_pend & (~fetch_pend | (last_grant_reg == GNT_FETCH));

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        m_req_next      = m_req_reg;
        m_we_next       = m_we_reg;
        m_addr_next     = m_addr_reg;
        m_be_next       = m_be_reg;
        m_wdata_next    = m_wdata_reg;
        if_rdata_next   = if_rdata_reg;
        d_rdata_next    = d_rdata_reg;
        if_ack_next     = 1'b0;
        d_ack_next      = 1'b0;
        bus_err_next    = 1'b0;

        unique case (state_reg)
            ARB_IDLE: begin
                if (grant_data) begin
                    m_req_next      = 1'b1;
                    m_we_next       = d_store;   // load+store together acts as a store
                    m_addr_next     = d_addr;
                    m_be_next       = d_be;
                    m_wdata_next    = d_wdata;
                    last_grant_next = GNT_DATA;
                    state_next      = ARB_DATA_BUSY;
                end else if (fetch_pend) begin
                    m_req_next      = 1'b1;
                    m_we_next       = 1'b0;
                    m_addr_next     = if_addr;
                    m_be_next       = 4'hF;
                    m_wdata_next    = '0;
                    last_grant_next = GNT_FETCH;
                    state_next      = ARB_FETCH_BUSY;
                end
            end
            ARB_FETCH_BUSY, ARB_DATA_BUSY: begin
                if (m_ack || timer_expired) begin
                    m_req_next   = 1'b0;
                    state_next   = ARB_IDLE;
                    bus_err_next = ~m_ack;
                    if (state_reg == ARB_FETCH_BUSY) begin
                        if_ack_next   = 1'b1;
                        if_rdata_next = m_ack ? m_rdata : ERR_RDATA;
                    end else begin
                        d_ack_next = 1'b1;
                        if (!m_we_reg) begin
                            d_rdata_next = m_ack ? m_rdata : ERR_RDATA;
                        end
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
                m_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARB_IDLE;
            last_grant_reg <= GNT_FETCH;
            m_req_reg      <= 1'b0;
            m_we_reg       <= 1'b0;
            m_addr_reg     <= '0;
            m_be_reg       <= '0;
            m_wdata_reg    <= '0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            if_ack_reg     <= 1'b0;
            d_ack_reg      <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            m_req_reg      <= m_req_next;
            m_we_reg       <= m_we_next;
            m_addr_reg     <= m_addr_next;
            m_be_reg       <= m_be_next;
            m_wdata_reg    <= m_wdata_next;
            if_rdata_reg   <= if_rdata_next;
            d_rdata_reg    <= d_rdata_next;
            if_ack_reg     <= if_ack_next;
            d_ack_reg      <= d_ack_next;
            bus_err_reg    <= bus_err_next;
        end
    end

    assign m_req    = m_req_reg;
    assign m_we     = m_we_reg;
    assign m_addr   = m_addr_reg;
    assign m_be     = m_be_reg;
    assign m_wdata  = m_wdata_reg;
    assign if_rdata = if_rdata_reg;
    assign d_rdata  = d_rdata_reg;
    assign if_ack   = if_ack_reg;
    assign d_ack    = d_ack_reg;
    assign bus_err  = bus_err_reg;
    assign stall    = (d_load | d_store) & ~d_ack_reg;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter (watchdog set to 4 cycles).
// A vector table drives single-requester accesses with a chosen bus ack
// delay; hand sequences cover the reset-time tie, alternating round-robin
// and reset in the middle of an access.
module tb_rv32i_mem_arbiter;

    localparam int TO = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_load, d_store;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        stall;
    logic        m_req, m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_err;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_if;
    logic [31:0] exp_d;

    always #5 clk = ~clk;

    rv32i_mem_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (ERR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_rdata(if_rdata),
        .if_ack  (if_ack),
        .d_load  (d_load),
        .d_store (d_store),
        .d_addr  (d_addr),
        .d_be    (d_be),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .stall   (stall),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_be    (m_be),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .bus_err (bus_err)
    );

    // kind: 0 fetch, 1 load, 2 store, 3 load+store together
    // delay: m_req cycle in which m_ack is returned (1 = first); 0 = never
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0; if_addr = '0;
        d_load  = 1'b0; d_store = 1'b0;
        d_addr  = '0;   d_be    = '0; d_wdata = '0;
        m_ack   = 1'b0; m_rdata = 32'h0BAD0BAD;
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the ack cycle.
    task automatic apply_vec(input int idx, input vec_t v);
        bit   err;
        int   mreq_n, ack_c;
        logic [4:0] exp_flags;
        err    = (v.delay == 0) || (v.delay > TO);
        mreq_n = err ? TO : v.delay;
        ack_c  = mreq_n + 1;
        if (v.kind == 0) begin
            if_req = 1'b1; if_addr = v.addr;
            exp_if = err ? ERR : v.rdata;
        end else begin
            d_load  = (v.kind == 1) || (v.kind == 3);
            d_store = (v.kind >= 2);
            d_addr  = v.addr; d_be = v.be; d_wdata = v.wdata;
            if (v.kind == 1) exp_d = err ? ERR : v.rdata;
        end
        #1;
        for (int c = 0; c <= ack_c + 1; c++) begin
            if (c > 0) step();
            exp_flags = {(c >= 1 && c <= mreq_n), (v.kind == 0 && c == ack_c),
                         (v.kind != 0 && c == ack_c), (v.kind != 0 && c < ack_c),
                         (err && c == ack_c)};
            chk($sformatf("v%0d c%0d req/ifack/dack/stall/err", idx, c),
                {m_req, if_ack, d_ack, stall, bus_err}, exp_flags);
            if (c >= 1 && c <= mreq_n) begin
                chk($sformatf("v%0d c%0d m_addr/we/be", idx, c), {m_addr, m_we, m_be},
                    {v.addr, (v.kind >= 2), (v.kind == 0) ? 4'hF : v.be});
                if (v.kind != 0) chk($sformatf("v%0d c%0d m_wdata", idx, c), m_wdata, v.wdata);
            end
            if (c == ack_c) begin
                if (v.kind == 0) chk($sformatf("v%0d if_rdata", idx), if_rdata, exp_if);
                else             chk($sformatf("v%0d d_rdata", idx), d_rdata, exp_d);
                idle_inputs();
            end else begin
                m_ack   = (c >= 1) && (c == v.delay);
                m_rdata = m_ack ? v.rdata : 32'h0BAD0BAD;
            end
        end
    endtask

    initial begin
        vecs[0] = '{0, 32'h00000100, 4'hF, 32'h0,        1, 32'h00000013}; // fetch, ack in 1st cycle
        vecs[1] = '{2, 32'h00003000, 4'hC, 32'hAB000000, 3, 32'h55555555}; // store, wait states
        vecs[2] = '{1, 32'h00004000, 4'hF, 32'h0,        0, 32'h0};        // load timeout
        vecs[3] = '{1, 32'h00005000, 4'hF, 32'h0,        4, 32'h12345678}; // ack coincides with timeout
        vecs[4] = '{1, 32'h00006000, 4'h3, 32'h0,        2, 32'hCAFEF00D}; // load, 1 wait
        vecs[5] = '{0, 32'h00000104, 4'hF, 32'h0,        0, 32'h0};        // fetch timeout
        vecs[6] = '{2, 32'h00007000, 4'h1, 32'h000000EE, 0, 32'h0};        // store timeout
        vecs[7] = '{3, 32'h00008000, 4'hF, 32'h11223344, 1, 32'h99999999}; // load+store -> store

        idle_inputs();
        reset = 1'b1;
        step(); step();
        chk("reset outputs", {m_req, if_ack, d_ack, bus_err, stall, m_we, m_addr, m_be, m_wdata, if_rdata, d_rdata}, '0);
        reset = 1'b0;
        exp_if = '0; exp_d = '0;

        // Tie right after reset with both requests held: data, fetch, data, fetch.
        if_req = 1'b1; if_addr = 32'h00000200;
        d_load = 1'b1; d_addr = 32'h00002000; d_be = 4'hF;
        #1;
        for (int c = 1; c <= 12; c++) begin
            int  k, ph;
            bit  dturn;
            step();
            k = (c - 1) / 3; ph = (c - 1) % 3;
            dturn = (k % 2) == 0;
            if (c == 12) begin
                chk("tie end idle", {m_req, if_ack, d_ack, stall}, 4'b0000);
            end else if (ph == 0) begin
                chk($sformatf("tie c%0d grant", c), {m_req, m_we, m_addr},
                    {2'b10, dturn ? 32'h00002000 : 32'h00000200});
                chk($sformatf("tie c%0d stall", c), stall, 1'b1);
                m_ack = 1'b1; m_rdata = 32'h1000 + k;
            end else if (ph == 1) begin
                m_ack = 1'b0; m_rdata = 32'h0BAD0BAD;
                chk($sformatf("tie c%0d acks/stall", c), {m_req, d_ack, if_ack, stall, bus_err},
                    {1'b0, dturn, !dturn, !dturn, 1'b0});
                if (dturn) chk($sformatf("tie c%0d d_rdata", c), d_rdata, 32'h1000 + k);
                else       chk($sformatf("tie c%0d if_rdata", c), if_rdata, 32'h1000 + k);
                if (c == 11) idle_inputs();
            end else begin
                chk($sformatf("tie c%0d gap", c), {m_req, d_ack, if_ack, stall}, 4'b0001);
            end
        end
        exp_d = 32'h1002; exp_if = 32'h1003;

        for (int i = 0; i < 8; i++) apply_vec(i, vecs[i]);

        // Reset during the second BUSY cycle of a load.
        d_load = 1'b1; d_addr = 32'h00009000; d_be = 4'hF;
        #1;
        step();
        chk("rst c1 m_req", {m_req, m_addr}, {1'b1, 32'h00009000});
        step();
        chk("rst c2 m_req", m_req, 1'b1);
        reset = 1'b1;
        idle_inputs();
        step();
        chk("rst c3 outputs", {m_req, if_ack, d_ack, bus_err, stall, m_we, m_addr, m_be, m_wdata, if_rdata, d_rdata}, '0);
        reset = 1'b0;
        exp_if = '0; exp_d = '0;
        step();
        chk("rst c4 no ack", {m_req, if_ack, d_ack, bus_err}, 4'b0000);
        apply_vec(8, vecs[4]);
        apply_vec(9, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
